// File: rtl/gray_mon_pkg.sv
// Shared types and helpers for the Gray-count monitor: tracking states and
// a Gray-to-binary decoder usable for any width up to GRAY_MAX_W.
package gray_mon_pkg;

    localparam int GRAY_MAX_W = 32;

    typedef enum logic [1:0] {
        ACQ    = 2'd0,
        TRACK  = 2'd1,
        RESYNC = 2'd2
    } mon_state_e;

    // Zero-extended codes decode correctly because the extra high bits are 0.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] d;
        d[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            d[i] = d[i+1] ^ g[i];
        end
        return d;
    endfunction

endpackage

// File: rtl/gray_count_monitor_if.sv
// Bundle between the upstream Gray counter side (master) and the monitor (slave).
interface gray_count_monitor_if #(
    parameter int W         = 4,
    parameter int ERR_CNT_W = 8
);
    logic [W-1:0]         gray_in;
    logic                 clr;
    logic [W-1:0]         bin_out;
    logic                 bin_valid;
    logic                 step;
    logic                 wrap;
    logic                 err;
    logic                 err_sticky;
    logic [ERR_CNT_W-1:0] err_count;

    modport master (
        output gray_in, clr,
        input  bin_out, bin_valid, step, wrap, err, err_sticky, err_count
    );

    modport slave (
        input  gray_in, clr,
        output bin_out, bin_valid, step, wrap, err, err_sticky, err_count
    );
endinterface

// File: rtl/gray_sync.sv
// Plain W-bit by STAGES-deep flop chain for bringing a Gray bus into clk.
module gray_sync #(
    parameter int W      = 4,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stage_r [STAGES];

    // Shift the asynchronous input through the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_r[i] <= '0;
            end
        end else begin
            stage_r[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign q = stage_r[STAGES-1];

endmodule

// File: rtl/gray_count_monitor.sv
// Synchronises an upstream Gray count, decodes it and checks single steps.
// Optional error counter enabled by defining GRAY_MON_ERR_CNT_EN.
module gray_count_monitor
    import gray_mon_pkg::*;
#(
    parameter int W           = 4,
    parameter int SYNC_STAGES = 2,
    parameter int STABLE_CYC  = 4,
    parameter int ERR_CNT_W   = 8
) (
    input logic               clk,
    input logic               rst_n,
    gray_count_monitor_if.slave bus
);

    localparam int FILL_W = $clog2(SYNC_STAGES + 1);

    logic [W-1:0]      sync_s;
    logic [W-1:0]      d_s;
    logic [W-1:0]      delta_s;
    logic [3:0]        clean_next_s;
    logic              bad_s;

    mon_state_e        state_r;
    logic [FILL_W-1:0] fill_r;
    logic [3:0]        clean_r;
    logic [W-1:0]      bin_r;
    logic              valid_r;
    logic              step_r;
    logic              wrap_r;
    logic              err_r;
    logic              sticky_r;

    gray_sync #(
        .W      (W),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.gray_in),
        .q     (sync_s)
    );

    // Decode and compare against the last accepted value.
    always_comb begin
        d_s          = W'(gray2bin(GRAY_MAX_W'(sync_s)));
        delta_s      = d_s - bin_r;
        clean_next_s = clean_r + 4'd1;
        bad_s        = (state_r == TRACK) && (delta_s != W'(0)) && (delta_s != W'(1));
    end

    // Acquire / track / resync state machine with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ACQ;
            fill_r  <= '0;
            clean_r <= 4'd0;
            bin_r   <= '0;
            valid_r <= 1'b0;
            step_r  <= 1'b0;
            wrap_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            step_r <= 1'b0;
            wrap_r <= 1'b0;
            err_r  <= 1'b0;
            case (state_r)
                ACQ: begin
                    if (fill_r == FILL_W'(SYNC_STAGES)) begin
                        bin_r   <= d_s;
                        valid_r <= 1'b1;
                        fill_r  <= '0;
                        state_r <= TRACK;
                    end else begin
                        fill_r <= fill_r + FILL_W'(1);
                    end
                end
                TRACK: begin
                    if (delta_s == W'(1)) begin
                        bin_r  <= d_s;
                        step_r <= 1'b1;
                        wrap_r <= (bin_r == {W{1'b1}});
                    end else if (bad_s) begin
                        bin_r   <= d_s;
                        err_r   <= 1'b1;
                        valid_r <= 1'b0;
                        clean_r <= 4'd0;
                        state_r <= RESYNC;
                    end else begin
                        bin_r <= bin_r;
                    end
                end
                RESYNC: begin
                    bin_r <= d_s;
                    // A bad delta here only restarts the stability window.
                    if (delta_s <= W'(1)) begin
                        if (clean_next_s == 4'(STABLE_CYC)) begin
                            clean_r <= 4'd0;
                            valid_r <= 1'b1;
                            state_r <= TRACK;
                        end else begin
                            clean_r <= clean_next_s;
                        end
                    end else begin
                        clean_r <= 4'd0;
                    end
                end
                default: begin
                    state_r <= ACQ;
                    fill_r  <= '0;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Sticky error flag: a new error outranks a coincident clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_r <= 1'b0;
        end else if (bad_s) begin
            sticky_r <= 1'b1;
        end else if (bus.clr) begin
            sticky_r <= 1'b0;
        end else begin
            sticky_r <= sticky_r;
        end
    end

`ifdef GRAY_MON_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] cnt_r;

    // Saturating error counter; clear with a coincident error leaves one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (bad_s) begin
            if (bus.clr) begin
                cnt_r <= ERR_CNT_W'(1);
            end else if (cnt_r != {ERR_CNT_W{1'b1}}) begin
                cnt_r <= cnt_r + ERR_CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end else if (bus.clr) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign bus.err_count = cnt_r;
`else
    assign bus.err_count = ERR_CNT_W'(0);
`endif

    assign bus.bin_out    = bin_r;
    assign bus.bin_valid  = valid_r;
    assign bus.step       = step_r;
    assign bus.wrap       = wrap_r;
    assign bus.err        = err_r;
    assign bus.err_sticky = sticky_r;

endmodule

// File: doc/gray_count_monitor.md
# gray_count_monitor

- Receives the 4-bit Gray count from the upstream Gray/binary counter, which may run on an unrelated clock.
- Synchronises the count into the local `clk` domain and decodes it back to binary.
- Checks that every observed transition is a legal single step, pulsing on each step and on each wrap.
- Flags and recovers from corrupted or skipped codes.
- Sits directly downstream of the counter, as its consumer.

## Interface
Parameters:
- `W`, 4, Gray/binary width.
- `SYNC_STAGES`, 2, synchroniser depth; legal values ≥ 2.
- `STABLE_CYC`, 4, consecutive clean cycles required to leave RESYNC; legal values 1..15.
- `ERR_CNT_W`, 8, error counter width.

Ports:
- `clk`  in  1  sole clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `gray_in`  in  W  Gray count from upstream; treated as asynchronous.
- `clr`  in  1  synchronous clear of `err_sticky` and `err_count`.
- `bin_out`  out  W  decoded binary count, registered.
- `bin_valid`  out  1  high while in TRACK.
- `step`  out  1  one-cycle pulse: decoded value advanced by exactly +1.
- `wrap`  out  1  one-cycle pulse: step from 2^W−1 to 0 (coincides with `step`).
- `err`  out  1  one-cycle pulse: illegal delta detected in TRACK.
- `err_sticky`  out  1  set by `err`, cleared only by `clr` or reset.
- `err_count`  out  ERR_CNT_W  saturating error count.

## Operation
- **Reset (`rst_n` low):** all synchroniser flops, `bin_out`, `err_count` cleared to 0. `bin_valid`, `step`, `wrap`, `err`, `err_sticky` = 0. State = ACQ, fill counter = 0.
- **Decode:** `d` = gray-to-binary of the last synchroniser stage (`d[W-1]=g[W-1]`, `d[i]=d[i+1]^g[i]`). Delta = (`d` − `bin_out`) mod 2^W.
- **ACQ:**
  - Count SYNC_STAGES cycles to flush the synchroniser, then load `bin_out`←`d`.
  - Go to TRACK.
  - No `step`/`err` pulses.
- **TRACK (`bin_valid`=1), per cycle:**
  - Delta 0: hold.
  - Delta 1: `bin_out`←`d`, `step`=1; `wrap`=1 if the old `bin_out` was all ones.
  - Any other delta: `bin_out`←`d`, `err`=1, `err_sticky`←1, `err_count`+1 (saturating at all ones); go to RESYNC with clean counter = 0.
- **RESYNC (`bin_valid`=0):**
  - `bin_out`←`d` every cycle; no pulses.
  - Delta 0 or 1 increments the clean counter. Any other delta resets it to 0 without raising `err`.
  - When the counter reaches STABLE_CYC, go to TRACK.
- **`clr`:**
  - `clr` coincident with `err`: set wins. `err_sticky`=1, `err_count`=1.
  - `clr` alone: both cleared to 0.
- **Reset mid-operation:** immediate return to reset values and ACQ; no residual pulse.

## Timing
- A `gray_in` value sampled at edge k reaches the last synchroniser stage at edge k+SYNC_STAGES−1. The resulting `bin_out`/`step`/`wrap`/`err` update is visible after edge k+SYNC_STAGES.
- All outputs are registered; no combinational path from `gray_in`.
- First `bin_valid`=1 occurs SYNC_STAGES+1 edges after `rst_n` deassertion.
- After an error, `bin_valid` returns high after STABLE_CYC clean cycles, at the earliest.
- Pulses last exactly one cycle. Back-to-back steps produce back-to-back pulses.

## Configuration
- `GRAY_MON_ERR_CNT_EN` defined: `err_count` is implemented as described.
- Macro undefined:
  - Counter logic is removed and `err_count` is tied to 0.
  - `err` and `err_sticky` behave unchanged.

## Structure
- **Package `gray_mon_pkg`:** state enum (ACQ, TRACK, RESYNC) and function `gray2bin` (width-generic via W).
- **Sub-module `gray_sync`:** parameterised W × SYNC_STAGES flop chain with asynchronous active-low reset. It contains no logic besides flops and is reused by other cross-domain paths.

## Test plan
- **Reset/acquire:** hold `gray_in`=4'b0110 through reset release. After 3 edges: `bin_out`=4, `bin_valid`=1, `step`=0, `err`=0.
- **Legal sweep:** drive the Gray sequence 0→1→3→2…→8 (binary 0..15 then 0), one code per 2 clocks.
  - 16 `step` pulses.
  - Exactly one `wrap`, when `bin_out` goes 15→0.
  - `err` never asserted.
- **Illegal jump:** in TRACK at `bin_out`=5, force Gray of 9.
  - One `err` pulse; `err_sticky`=1; `err_count`=1; `bin_valid`=0.
  - With `gray_in` held, `bin_valid`=1 again after 4 cycles.
- **RESYNC restart:** during RESYNC after clean count 3, inject another bad jump. Clean counter restarts, no extra `err`, `err_count` stays 1.
- **Clear race:** assert `clr` in the same cycle as an error → `err_sticky`=1, `err_count`=1. Then `clr` alone → both 0.
- **Saturation/macro:**
  - With `ERR_CNT_W`=2, force 5 errors → `err_count`=3.
  - Rebuilt without `GRAY_MON_ERR_CNT_EN` → `err_count`=0 throughout.
